// File: rtl/gen3_framing_pkg.sv
// gen3_framing_pkg: shared constants and types for the Gen3 multi-lane framing parser.
//   - Framing token byte values (SDP, STP nibble, EDB, idle).
//   - One-hot per-byte type codes. An all-zero code means not_valid.
//   - Per-byte framing state enum.
package gen3_framing_pkg;

   localparam logic [7:0] SDP_BYTE1 = 8'hF0;
   localparam logic [7:0] SDP_BYTE2 = 8'h53;
   localparam logic [3:0] STP_NIB   = 4'hF;
   localparam logic [7:0] EDB_BYTE  = 8'hC0;
   localparam logic [7:0] IDL       = 8'h00;

   localparam int unsigned TYPE_W = 6;

   localparam logic [TYPE_W-1:0] TYPE_NONE      = 6'b000000;
   localparam logic [TYPE_W-1:0] TYPE_DATA      = 6'b000001;
   localparam logic [TYPE_W-1:0] TYPE_TLPSTART  = 6'b000010;
   localparam logic [TYPE_W-1:0] TYPE_TLPEND    = 6'b000100;
   localparam logic [TYPE_W-1:0] TYPE_DLLPSTART = 6'b001000;
   localparam logic [TYPE_W-1:0] TYPE_DLLPEND   = 6'b010000;
   localparam logic [TYPE_W-1:0] TYPE_TLPEDB    = 6'b100000;

   typedef enum logic [2:0] {
      StIdle,
      StSdp1,
      StStp1,
      StStp2,
      StStp3,
      StTlp,
      StDllp
   } state_e;

endpackage

// File: rtl/gen3_byte_step.sv
// gen3_byte_step: combinational single-byte framing step.
//   Takes the framing state produced by the previous byte plus the current byte and returns
//   the next state, the byte's one-hot type and an error flag. Chained once per lane.
// Ports:
//   cur_state/cur_cnt/cur_lim   state entering this byte
//   byte_in                     byte being classified
//   next_state/next_cnt/next_lim state leaving this byte
//   byte_type                   one-hot type (0 = not_valid)
//   err                         framing error on this byte
// Build option: GEN3_EDB_DETECT_EN types a 0xC0 TLP end byte as tlpedb.
module gen3_byte_step
   import gen3_framing_pkg::*;
#(
   parameter int unsigned CNT_W    = 13,
   parameter int unsigned DLLP_LEN = 6
) (
   input  state_e             cur_state,
   input  logic [CNT_W-1:0]   cur_cnt,
   input  logic [CNT_W-1:0]   cur_lim,
   input  logic [7:0]         byte_in,
   output state_e             next_state,
   output logic [CNT_W-1:0]   next_cnt,
   output logic [CNT_W-1:0]   next_lim,
   output logic [TYPE_W-1:0]  byte_type,
   output logic               err
);

   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] lim_bytes;
   logic [CNT_W-1:0] tlp_last;

   assign cnt_inc   = cur_cnt + CNT_W'(1);
   // Length field is in DWs; the stored limit is converted to bytes on the STP2 byte.
   assign lim_bytes = cur_lim << 2;
   // TLP body ends 4 bytes short of the limit: the STP token itself occupies 4 bytes.
   assign tlp_last  = cur_lim - CNT_W'(4);

   always_comb begin
      next_state = cur_state;
      next_cnt   = cur_cnt;
      next_lim   = cur_lim;
      byte_type  = TYPE_NONE;
      err        = 1'b0;
      unique case (cur_state)
         StIdle: begin
            if (byte_in == SDP_BYTE1) begin
               next_state = StSdp1;
            end else if (byte_in[3:0] == STP_NIB) begin
               next_state = StStp1;
               next_lim   = {{(CNT_W-4){1'b0}}, byte_in[7:4]};
            end else if (byte_in != IDL) begin
               err = 1'b1;
            end
         end
         StSdp1: begin
            if (byte_in == SDP_BYTE2) begin
               next_state = StDllp;
               next_cnt   = '0;
               byte_type  = TYPE_DLLPSTART;
            end else begin
               next_state = StIdle;
               err        = 1'b1;
            end
         end
         StStp1: begin
            next_state = StStp2;
            next_lim   = {{(CNT_W-11){1'b0}}, byte_in[6:0], cur_lim[3:0]};
         end
         StStp2: begin
            if (lim_bytes < CNT_W'(8)) begin
               next_state = StIdle;
               err        = 1'b1;
            end else begin
               next_state = StStp3;
               next_lim   = lim_bytes;
            end
         end
         StStp3: begin
            next_state = StTlp;
            next_cnt   = '0;
            byte_type  = TYPE_TLPSTART;
         end
         StTlp: begin
            if (cnt_inc < tlp_last) begin
               next_cnt  = cnt_inc;
               byte_type = TYPE_DATA;
            end else begin
               next_state = StIdle;
`ifdef GEN3_EDB_DETECT_EN
               byte_type  = (byte_in == EDB_BYTE) ? TYPE_TLPEDB : TYPE_TLPEND;
`else
               byte_type  = TYPE_TLPEND;
`endif
            end
         end
         StDllp: begin
            if (cnt_inc < CNT_W'(DLLP_LEN)) begin
               next_cnt  = cnt_inc;
               byte_type = TYPE_DATA;
            end else begin
               next_state = StIdle;
               byte_type  = TYPE_DLLPEND;
            end
         end
         default: begin
            next_state = StIdle;
         end
      endcase
   end

endmodule

// File: rtl/gen3_framing_parser.sv
// gen3_framing_parser: registered multi-lane Gen3 framing classifier.
//   Tags LANES bytes per clock with a one-hot type (data, tlpstart, tlpend, dllpstart,
//   dllpend, tlpedb) and pulses framing_err on malformed framing. One cycle of latency.
// Ports:
//   clk, rst (async, active-low)
//   data_in     LANES bytes, byte 0 at [7:0] is first in stream order
//   valid       data_in qualifier
//   syncHeader  sync header of the current block
//   data_out    registered data_in
//   type_out    6 bits per lane, lane i at [6i+5:6i]
//   valid_out   registered valid
//   framing_err single-cycle error pulse
// Build option: GEN3_EDB_DETECT_EN (see gen3_byte_step).
// LANES must be 1, 2 or 4.
module gen3_framing_parser
   import gen3_framing_pkg::*;
#(
   parameter int unsigned LANES     = 4,
   parameter int unsigned CNT_W     = 13,
   parameter int unsigned DLLP_LEN  = 6,
   parameter logic [1:0]  DATA_SYNC = 2'b01
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [8*LANES-1:0]        data_in,
   input  logic                      valid,
   input  logic [1:0]                syncHeader,
   output logic [8*LANES-1:0]        data_out,
   output logic [TYPE_W*LANES-1:0]   type_out,
   output logic                      valid_out,
   output logic                      framing_err
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] lim_q;

   // Lane i consumes link i and produces link i+1; link LANES is the registered next state.
   state_e                    st_link  [LANES+1];
   logic [CNT_W-1:0]          cnt_link [LANES+1];
   logic [CNT_W-1:0]          lim_link [LANES+1];
   logic [TYPE_W*LANES-1:0]   lane_type;
   logic [LANES-1:0]          lane_err;

   assign st_link[0]  = state_q;
   assign cnt_link[0] = cnt_q;
   assign lim_link[0] = lim_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      gen3_byte_step #(
         .CNT_W    (CNT_W),
         .DLLP_LEN (DLLP_LEN)
      ) u_step (
         .cur_state  (st_link[i]),
         .cur_cnt    (cnt_link[i]),
         .cur_lim    (lim_link[i]),
         .byte_in    (data_in[8*i +: 8]),
         .next_state (st_link[i+1]),
         .next_cnt   (cnt_link[i+1]),
         .next_lim   (lim_link[i+1]),
         .byte_type  (lane_type[TYPE_W*i +: TYPE_W]),
         .err        (lane_err[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         lim_q       <= '0;
         data_out    <= '0;
         type_out    <= '0;
         valid_out   <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         data_out    <= data_in;
         valid_out   <= valid;
         type_out    <= '0;
         framing_err <= 1'b0;
         if (valid) begin
            if (syncHeader != DATA_SYNC) begin
               // Ordered-set block: nothing is typed; an open token is abandoned.
               framing_err <= (state_q != StIdle);
               state_q     <= StIdle;
            end else begin
               state_q     <= st_link[LANES];
               cnt_q       <= cnt_link[LANES];
               lim_q       <= lim_link[LANES];
               type_out    <= lane_type;
               framing_err <= |lane_err;
            end
         end
      end
   end

endmodule

// File: doc/gen3_framing_parser.md
Name: gen3_framing_parser

Overview:
- Registered, multi-lane successor to the Gen3 per-byte framing classifier.
- Sits after the Gen3 block/sync-header stripper and before TLP/DLLP extraction.
- Consumes LANES bytes per clock and tags each byte with a one-hot type: data, tlpstart, tlpend, dllpstart, dllpend or tlpedb.
- Keeps all framing state (header phase, byte counter, length limit) internally and flags framing errors.

Parameters:
- LANES, 4, bytes per cycle; legal values 1, 2, 4.
- CNT_W, 13, counter width; must hold 2047*4.
- DLLP_LEN, 6, DLLP payload bytes following the SDP token.
- DATA_SYNC, 2'b01, sync-header value marking a data block.

Ports:
- clk  in  1  clock
- rst  in  1  async active-low reset
- data_in  in  8*LANES  byte i at [8i+7:8i]; byte 0 is first in stream order
- valid  in  1  data_in qualifies this cycle
- syncHeader  in  2  sync header of the current block
- data_out  out  8*LANES  registered copy of data_in
- type_out  out  6*LANES  per-byte one-hot type
- valid_out  out  1  registered valid
- framing_err  out  1  one-cycle error pulse

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst. While rst=0, every output is 0, state is IDLE, counter and limit are 0. Reset mid-packet discards the packet; no end type is emitted.
- Latency: exactly 1 cycle, data_in/valid -> data_out/type_out/valid_out.
- Cycles with valid=0 hold all state; valid_out=0 and type_out=0.
- If valid=1 and syncHeader != DATA_SYNC: every byte is typed not_valid. If state != IDLE, assert framing_err and return to IDLE.
- Byte processing: bytes are handled in order 0..LANES-1. The state produced by byte i feeds byte i+1 in the same cycle, and the final state is registered.
- Per-byte FSM:
  - IDLE:
    - 0x00 -> not_valid (idle).
    - 0xF0 -> SDP1, type not_valid.
    - low nibble 0xF -> STP1, limit[3:0]=byte[7:4].
    - anything else -> framing_err, stay IDLE.
  - SDP1: 0x53 -> DLLP, type dllpstart, counter=0. Otherwise framing_err -> IDLE.
  - STP1: limit[10:4]=byte[6:0] -> STP2.
  - STP2: limit=limit*4 (bytes). If limit<8, framing_err -> IDLE; otherwise -> STP3.
  - STP3: type tlpstart, counter=0 -> TLP.
  - TLP:
    - counter+1 < limit-4 -> type data, counter++.
    - counter+1 == limit-4 -> type tlpend (or tlpedb, see feature), -> IDLE.
  - DLLP: same rule against DLLP_LEN with type dllpend, -> IDLE.
- Counter arithmetic is CNT_W unsigned and never wraps, because limit is bounded at 8188.
- A new token may begin in the lane immediately after an end byte in the same cycle.
- framing_err ORs all lanes of the cycle and is a single pulse; after an error, remaining lanes of that cycle restart from IDLE.

Optional Feature:
- Macro GEN3_EDB_DETECT_EN.
- Defined: the TLP end byte equal to 0xC0 is typed tlpedb instead of tlpend.
- Undefined: the end byte is always tlpend; the 0xC0 comparator is not synthesized.

Decomposition:
- Package gen3_framing_pkg holds:
  - token constants: SDP_BYTE1=0xF0, SDP_BYTE2=0x53, STP_NIB=0xF, EDB_BYTE=0xC0, IDL=0x00;
  - the 6-bit one-hot type constants;
  - the state enum.
- Sub-module gen3_byte_step: purely combinational single-byte next-state/type function, instantiated LANES times in a chain. The top level holds the registers.

Test Plan:
- LANES=4, reset; stream F0 53 followed by 6 payload bytes -> types dllpstart, data x5, dllpend. Next byte 00 -> not_valid; framing_err=0.
- STP with byte0=0x3F, byte1=0x00 (LEN=3 DW, limit 12) -> after STP3 tlpstart, 7 data bytes, then tlpend on the 8th byte after tlpstart.
- Same TLP with final byte 0xC0 -> tlpedb when GEN3_EDB_DETECT_EN is defined, tlpend when it is not.
- Mid-TLP cycle with syncHeader=2'b10 -> framing_err=1 for exactly one cycle; next STP parses normally.
- IDLE byte 0x55 -> framing_err; STP with LEN=1 -> framing_err.
- rst dropped asynchronously mid-DLLP -> outputs are 0 immediately; after release, F0 53 is recognised as a fresh DLLP.
